// File: rtl/msk_aes_input_loader_pkg.sv
// Shared constants and state type for the masked AES input loader.
// Block layout: four plaintext words, then four key words.
package msk_aes_loader_pkg;

  localparam int WORDS_PT  = 4;
  localparam int WORDS_KEY = 4;
  localparam int BEATS     = 8;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } loader_state_e;

endpackage

// File: rtl/msk_aes_input_loader_if.sv
// Stream-in / core-out signal bundle of the masked AES input loader.
// The loader uses the slave modport; the environment drives through master.
interface msk_aes_input_loader_if #(parameter int d = 2);

  logic             in_valid;
  logic             in_ready;
  logic [32*d-1:0]  in_sh_word;
  logic             core_valid_in;
  logic             core_in_ready;
  logic [128*d-1:0] sh_plaintext;
  logic [128*d-1:0] sh_key;
  logic             busy;

  modport slave (
    input  in_valid,
    input  in_sh_word,
    input  core_in_ready,
    output in_ready,
    output core_valid_in,
    output sh_plaintext,
    output sh_key,
    output busy
  );

  modport master (
    output in_valid,
    output in_sh_word,
    output core_in_ready,
    input  in_ready,
    input  core_valid_in,
    input  sh_plaintext,
    input  sh_key,
    input  busy
  );

endinterface

// File: rtl/msk_aes_input_loader_word_bank.sv
// Four shared 32-bit words with select/write and a synchronous clear that
// wins over a write. Word w lands at bank[w*32*d +: 32*d].
module msk_aes_word_bank
  import msk_aes_loader_pkg::*;
#(
  parameter int d = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [1:0]       sel,
  input  logic [32*d-1:0]  wdata,
  output logic [128*d-1:0] bank
);

  logic [32*d-1:0] word_r [WORDS_PT];

  // Word storage: clear zeroizes every slot, otherwise only the selected slot loads.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORDS_PT; i++) begin
      if (clr) begin
        word_r[i] <= '0;
      end else if (we && (sel == 2'(i))) begin
        word_r[i] <= wdata;
      end
    end
  end

  for (genvar g = 0; g < WORDS_PT; g++) begin : g_pack
    assign bank[g*32*d +: 32*d] = word_r[g];
  end

endmodule

// File: rtl/msk_aes_input_loader.sv
// Collects eight shared words (plaintext then key) into two 128-bit sharings,
// presents them to the AES core, and zeroizes both banks when the core takes them.
module msk_aes_input_loader
  import msk_aes_loader_pkg::*;
#(
  parameter int d = 2
) (
  input logic                   clk,
  input logic                   rst,
  msk_aes_input_loader_if.slave bus
);

  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

  loader_state_e    state_r;
  loader_state_e    state_s;
  logic [2:0]       cnt_r;
  logic [2:0]       cnt_s;
  logic             accept_s;
  logic             xfer_s;
  logic             clear_s;
  logic             we_pt_s;
  logic             we_key_s;
  logic [128*d-1:0] pt_bank_s;
  logic [128*d-1:0] key_bank_s;

  // in_sh_word is only looked at while filling; FULL ignores the stream.
  assign accept_s = bus.in_valid && (state_r == FILL);
  assign xfer_s   = bus.core_in_ready && (state_r == FULL);
  assign clear_s  = xfer_s || rst;
  assign we_pt_s  = accept_s && !cnt_r[2];
  assign we_key_s = accept_s && cnt_r[2];

  // State and beat counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FILL;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state: count beats while filling, hold in FULL until the core accepts.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      FILL: begin
        if (accept_s) begin
          cnt_s = cnt_r + 3'd1;
          if (cnt_r == LAST_BEAT) begin
            state_s = FULL;
          end else begin
            state_s = FILL;
          end
        end else begin
          cnt_s   = cnt_r;
          state_s = FILL;
        end
      end
      FULL: begin
        if (bus.core_in_ready) begin
          state_s = FILL;
          cnt_s   = 3'd0;
        end else begin
          state_s = FULL;
          cnt_s   = cnt_r;
        end
      end
      default: begin
        state_s = FILL;
        cnt_s   = 3'd0;
      end
    endcase
  end

  msk_aes_word_bank #(.d(d)) u_pt_bank (
    .clk   (clk),
    .clr   (clear_s),
    .we    (we_pt_s),
    .sel   (cnt_r[1:0]),
    .wdata (bus.in_sh_word),
    .bank  (pt_bank_s)
  );

  msk_aes_word_bank #(.d(d)) u_key_bank (
    .clk   (clk),
    .clr   (clear_s),
    .we    (we_key_s),
    .sel   (cnt_r[1:0]),
    .wdata (bus.in_sh_word),
    .bank  (key_bank_s)
  );

  // Every output is a register or a decode of the state register.
  assign bus.in_ready      = (state_r == FILL);
  assign bus.core_valid_in = (state_r == FULL);
  assign bus.busy          = (cnt_r != 3'd0) || (state_r == FULL);
  assign bus.sh_plaintext  = pt_bank_s;
  assign bus.sh_key        = key_bank_s;

endmodule

// File: doc/msk_aes_input_loader.md
# msk_aes_input_loader

Serial-to-parallel front end for the masked 32-bit AES core. Accepts the masked plaintext and key one 32-bit shared word per beat over a valid/ready stream and assembles the 128-bit bit-compact sharings. Presents them to the core's `valid_in`/`in_ready` handshake and zeroizes the buffers once the core takes them. Sits directly upstream of the AES core, between the system bus adapter and the core.

## Interface

Parameters:
- `d`, default 2: number of shares; must match the core.

Ports:
- `clk`, input, 1: clock. One clock; every register is rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: upstream word valid.
- `in_ready`, output, 1: loader can accept a word.
- `in_sh_word`, input, 32*d: one shared word, bit-compact (share j of bit b at `[b*d+j]`).
- `core_valid_in`, output, 1: drives the core's `valid_in`.
- `core_in_ready`, input, 1: the core's `in_ready`.
- `sh_plaintext`, output, 128*d: to the core's `sh_plaintext`.
- `sh_key`, output, 128*d: to the core's `sh_key`.
- `busy`, output, 1: high when at least one word is held.

## Operation

- Word order per block is fixed, 8 beats total.
  - Beats 0–3 are plaintext words 0–3. Word w maps to `sh_plaintext[w*32*d +: 32*d]`, i.e. bits 32w..32w+31.
  - Beats 4–7 are key words 0–3, mapped the same way into `sh_key`.
- Beat counter `cnt`: 3 bits, 0..7. Increments on each accepted beat (`in_valid && in_ready`). Wraps 7→0 on the 8th beat.
- FSM, 2 states:
  - FILL: `in_ready`=1, `core_valid_in`=0. The accepted word is written to the slot selected by `cnt`; other slots hold. Transition to FULL on the beat with `cnt`==7.
  - FULL: `in_ready`=0, `core_valid_in`=1, buffers frozen. When `core_in_ready`=1, the transfer completes. Next cycle: state is FILL, `cnt`=0, both 128*d buffers are all-zero.
- Zeroization: buffers are cleared only by a completed transfer or by reset. There is no partial clear. Unwritten slots stay zero while filling.
- `in_valid` in FULL is ignored. No word is accepted and `in_sh_word` is not sampled.
- `core_in_ready` in FILL has no effect.
- `busy` = (`cnt`!=0) || FULL.
- There is no abort input. A partial block is discarded only by reset.

## Timing

- Reset: `rst` sampled high gives, next cycle: FILL, `cnt`=0, `in_ready`=1, `core_valid_in`=0, `busy`=0, `sh_plaintext`=0, `sh_key`=0. Reset overrides any simultaneous beat or transfer, including mid-fill and mid-FULL.
- Throughput into the loader: one word per cycle while in FILL.
- Latency: `core_valid_in` rises the cycle after the 8th accepted beat. With `in_valid` held high, that is cycle 8 after the first accept.
- Handshake hold: `core_valid_in` and the buffer contents are stable until the cycle after `core_in_ready`=1 is sampled in FULL.
- Return to FILL: `in_ready` re-asserts the cycle after the transfer. The minimum block period is therefore 8 load cycles + 1 transfer cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from `core_in_ready` or `in_valid` to any output.

## Structure

- Shared package `msk_aes_loader_pkg` holds:
  - constant `WORDS_PT`=4
  - constant `WORDS_KEY`=4
  - constant `BEATS`=8
  - state typedef `{FILL, FULL}`
- Sub-module `msk_aes_word_bank`, parameter `d`:
  - 4×32*d register bank with a 2-bit word select, write enable and synchronous clear.
  - Instantiated twice: plaintext bank, key bank.
  - Write enable for the plaintext bank is `cnt[2]`==0; for the key bank it is `cnt[2]`==1.
- Loader top holds the counter, the FSM and the clear generation (transfer || `rst`).

## Test plan

- Reset values: assert `rst` for 1 cycle with `in_valid`=1 and a random word. Next cycle: `in_ready`=1, `core_valid_in`=0, `busy`=0, both buses all-zero, no word written.
- Back-to-back load, d=2, with `in_valid` held and `core_in_ready`=0.
  - Stimulus: words 0x00000001..0x00000008, share 0 = value, share 1 = 0.
  - Required: `core_valid_in`=1 exactly 8 cycles after the first accept.
  - Required: unmasked `sh_plaintext` = 0x00000004_00000003_00000002_00000001 and unmasked `sh_key` = 0x00000008_00000007_00000006_00000005.
  - Required: `in_ready`=0 while `core_valid_in`=1.
- Backpressure hold: hold `core_in_ready`=0 for 20 cycles in FULL while driving `in_valid`=1 with garbage. Buffers are unchanged and `cnt` is unchanged. Then pulse `core_in_ready`=1 for one cycle: the next cycle has buffers all-zero, `in_ready`=1 and `busy`=0.
- Bubbles: accept a word only every third cycle. The 8 words land in the correct slots, `core_valid_in` rises the cycle after the 8th accept, and `busy`=1 from the first accept onward.
- Reset mid-fill: load 5 words, assert `rst`. Next cycle `cnt`=0 and both buses are zero. A fresh 8-word load then produces the new block only, with no residue from the discarded words.
- Random sharings, d=3: check that the recombined outputs (XOR of the shares) equal a reference recombination of the input words, and that the sharing is bit-exact, across 1000 blocks with random `core_in_ready` delays.
